// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage of the pipelined MIPS core. Owns the PC,
//            requests instruction words over a req/ready handshake and feeds
//            the IF/ID register with pcplus4_if / instr_if / fetch_valid.
//            A returned word is buffered while the pipeline is stalled. Branch
//            and jump redirects are accepted even with a request outstanding.
// Ports    : clk, rst (sync, active-high)
//            stall                        - IF/ID register holds this cycle
//            redirect_valid, redirect_pc  - taken branch/jump (beats stall)
//            imem_req, imem_addr          - memory request / word address
//            imem_ready, imem_rdata       - memory completion / data
//            pcplus4_if, instr_if         - presented PC+4 and instruction
//            fetch_valid                  - instr_if is real, not a bubble
//            bubble_count                 - bubble-cycle counter
// Options  : FETCH_BUBBLE_CNT_EN - when defined, bubble_count counts unstalled
//            bubble cycles (saturating); otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcplus4_if,
  output logic [31:0] instr_if,
  output logic        fetch_valid,
  output logic [31:0] bubble_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request outstanding at pc
    S_HOLD = 2'd1,  // word returned during a stall, waiting for release
    S_DROP = 2'd2   // redirected mid-request; finish the old request first
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_instr, hold_nxt;
  logic [31:0] target, target_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;

  assign pc_plus4         = pc + 32'd4;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_instr <= 32'd0;
      target     <= 32'd0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold_instr <= hold_nxt;
      target     <= target_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    hold_nxt    = hold_instr;
    target_nxt  = target;
    imem_req    = 1'b0;
    imem_addr   = pc;
    pcplus4_if  = pc_plus4;
    instr_if    = NOP_INSTR;
    fetch_valid = 1'b0;

    if (rst) begin
      // Any outstanding request is simply abandoned.
      pcplus4_if = RESET_PC + 32'd4;
    end else begin
      unique case (state)
        S_REQ: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            if (redirect_valid) begin
              // Wrong-path word: discard and refetch from the target.
              pc_nxt = redirect_aligned;
            end else if (stall) begin
              // IF/ID ignores this cycle; park the word until release.
              hold_nxt    = imem_rdata;
              state_nxt   = S_HOLD;
              instr_if    = imem_rdata;
              fetch_valid = 1'b1;
            end else begin
              instr_if    = imem_rdata;
              fetch_valid = 1'b1;
              pc_nxt      = pc_plus4;
            end
          end else if (redirect_valid) begin
            // The address must stay stable until the memory completes,
            // so remember where to go afterwards.
            target_nxt = redirect_aligned;
            state_nxt  = S_DROP;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            // Held word is on the wrong path; never present it again.
            pc_nxt    = redirect_aligned;
            state_nxt = S_REQ;
          end else begin
            instr_if    = hold_instr;
            fetch_valid = 1'b1;
            if (!stall) begin
              pc_nxt    = pc_plus4;
              state_nxt = S_REQ;
            end
          end
        end

        S_DROP: begin
          imem_req = 1'b1;
          if (redirect_valid) begin
            target_nxt = redirect_aligned;
          end
          if (imem_ready) begin
            pc_nxt    = redirect_valid ? redirect_aligned : target;
            state_nxt = S_REQ;
          end
        end

        default: begin
          state_nxt = S_REQ;
        end
      endcase
    end
  end

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= 32'd0;
    end else if (!fetch_valid && !stall && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign bubble_count = bubble_cnt;
`else
  assign bubble_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a behavioural
//            instruction memory that has a programmable number of wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pcplus4_if;
  logic [31:0] instr_if;
  logic        fetch_valid;
  logic [31:0] bubble_count;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int wcnt   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .pcplus4_if    (pcplus4_if),
    .instr_if      (instr_if),
    .fetch_valid   (fetch_valid),
    .bubble_count  (bubble_count)
  );

  // Memory contents: one known addi word, otherwise an address-tagged word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0008) return 32'h2008_0005;
    return {16'h2400, a[15:0]};
  endfunction

  // Memory completes after wait_n cycles of a held request.
  assign imem_ready = imem_req && (wcnt == wait_n);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (!imem_req || imem_ready) wcnt <= 0;
    else                         wcnt <= wcnt + 1;
  end

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; wait_n = 0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({imem_req, fetch_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_req_valid got %b expected 00", {imem_req, fetch_valid});
    end
    checks++;
    if (instr_if !== NOP) begin
      errors++; $display("FAIL reset_instr got %h expected %h", instr_if, NOP);
    end
    checks++;
    if (pcplus4_if !== 32'h0040_0004) begin
      errors++; $display("FAIL reset_pcplus4 got %h expected 00400004", pcplus4_if);
    end
    checks++;
    if (bubble_count !== 32'd0) begin
      errors++; $display("FAIL reset_bubble_count got %h expected 0", bubble_count);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      stall = (i == 2);  // stall lands on the cycle 0x400008 returns
      #1;
      a = RST_PC + 32'(4 * i);
      checks++;
      if ({imem_req, imem_addr, fetch_valid} !== {1'b1, a, 1'b1}) begin
        errors++; $display("FAIL seq_addr%0d got req=%b addr=%h valid=%b expected 1 %h 1",
                           i, imem_req, imem_addr, fetch_valid, a);
      end
      checks++;
      if ({pcplus4_if, instr_if} !== {a + 32'd4, mem_word(a)}) begin
        errors++; $display("FAIL seq_data%0d got %h %h expected %h %h",
                           i, pcplus4_if, instr_if, a + 32'd4, mem_word(a));
      end
    end
  endtask

  task automatic test_stall();
    // Two more stalled cycles in S_HOLD, then the release cycle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stall = (k < 2);
      #1;
      checks++;
      if ({imem_req, fetch_valid, instr_if, pcplus4_if} !== {2'b01, 32'h2008_0005, 32'h0040_000C}) begin
        errors++; $display("FAIL stall_hold%0d got req=%b valid=%b instr=%h pc4=%h expected 0 1 20080005 0040000c",
                           k, imem_req, fetch_valid, instr_if, pcplus4_if);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({imem_req, imem_addr, fetch_valid} !== {1'b1, 32'h0040_000C, 1'b1}) begin
      errors++; $display("FAIL stall_resume got req=%b addr=%h valid=%b expected 1 0040000c 1",
                         imem_req, imem_addr, fetch_valid);
    end
  endtask

  task automatic test_redirect_ready();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
    #1;
    checks++;
    if ({imem_addr, fetch_valid, instr_if} !== {32'h0040_0010, 1'b0, NOP}) begin
      errors++; $display("FAIL redir_ready_drop got addr=%h valid=%b instr=%h expected 00400010 0 %h",
                         imem_addr, fetch_valid, instr_if, NOP);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({imem_addr, fetch_valid, instr_if} !== {32'h0040_0100, 1'b1, mem_word(32'h0040_0100)}) begin
      errors++; $display("FAIL redir_ready_target got addr=%h valid=%b instr=%h expected 00400100 1 %h",
                         imem_addr, fetch_valid, instr_if, mem_word(32'h0040_0100));
    end
  endtask

  task automatic test_redirect_wait();
    @(negedge clk);
    wait_n = 2; redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
    #1;
    checks++;
    if ({imem_req, imem_addr, fetch_valid} !== {1'b1, 32'h0040_0104, 1'b0}) begin
      errors++; $display("FAIL drop_wait0 got req=%b addr=%h valid=%b expected 1 00400104 0",
                         imem_req, imem_addr, fetch_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, fetch_valid, instr_if} !== {1'b1, 32'h0040_0104, 1'b0, NOP}) begin
      errors++; $display("FAIL drop_wait1 got req=%b addr=%h valid=%b instr=%h expected 1 00400104 0 %h",
                         imem_req, imem_addr, fetch_valid, instr_if, NOP);
    end
    @(negedge clk); #1;
    checks++;
    if ({imem_ready, imem_addr, fetch_valid} !== {1'b1, 32'h0040_0104, 1'b0}) begin
      errors++; $display("FAIL drop_ready got ready=%b addr=%h valid=%b expected 1 00400104 0",
                         imem_ready, imem_addr, fetch_valid);
    end
    @(negedge clk); #1;
    checks++;
    if ({imem_req, imem_addr, fetch_valid} !== {1'b1, 32'h0040_0200, 1'b0}) begin
      errors++; $display("FAIL drop_target got req=%b addr=%h valid=%b expected 1 00400200 0",
                         imem_req, imem_addr, fetch_valid);
    end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({imem_addr, fetch_valid, instr_if} !== {32'h0040_0200, 1'b1, mem_word(32'h0040_0200)}) begin
      errors++; $display("FAIL drop_target_data got addr=%h valid=%b instr=%h expected 00400200 1 %h",
                         imem_addr, fetch_valid, instr_if, mem_word(32'h0040_0200));
    end
  endtask

  task automatic test_hold_redirect();
    @(negedge clk);
    wait_n = 0; stall = 1'b1;
    #1;
    checks++;
    if ({imem_addr, fetch_valid} !== {32'h0040_0204, 1'b1}) begin
      errors++; $display("FAIL hold_redir_fetch got addr=%h valid=%b expected 00400204 1",
                         imem_addr, fetch_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0300;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL hold_redir_req got %b expected 0", imem_req);
    end
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, fetch_valid, instr_if} !== {1'b1, 32'h0040_0300, 1'b1, mem_word(32'h0040_0300)}) begin
      errors++; $display("FAIL hold_redir_target got req=%b addr=%h valid=%b instr=%h expected 1 00400300 1 %h",
                         imem_req, imem_addr, fetch_valid, instr_if, mem_word(32'h0040_0300));
    end
    @(negedge clk); #1;
    checks++;
    if ({imem_addr, instr_if} !== {32'h0040_0304, mem_word(32'h0040_0304)}) begin
      errors++; $display("FAIL hold_redir_next got addr=%h instr=%h expected 00400304 %h",
                         imem_addr, instr_if, mem_word(32'h0040_0304));
    end
  endtask

  task automatic test_bubble_count();
    int          valids;
    logic [31:0] exp_cnt;
`ifdef FETCH_BUBBLE_CNT_EN
    exp_cnt = 32'd8;
`else
    exp_cnt = 32'd0;
`endif
    valids = 0;
    @(negedge clk);
    rst = 1'b1; wait_n = 2; stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (fetch_valid === 1'b1) valids++;
    end
    @(negedge clk); #1;
    checks++;
    if (valids != 4) begin
      errors++; $display("FAIL bubble_valids got %0d expected 4", valids);
    end
    checks++;
    if (imem_addr !== 32'h0040_0010) begin
      errors++; $display("FAIL bubble_addr got %h expected 00400010", imem_addr);
    end
    checks++;
    if (bubble_count !== exp_cnt) begin
      errors++; $display("FAIL bubble_count got %0d expected %0d", bubble_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_ready();
    test_redirect_wait();
    test_hold_redirect();
    test_bubble_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
